// File: rtl/ex_regfile_mp_pkg.sv
// Shared defaults for the multi-port register file: widths, register count and
// long-pipe port selection. E203_RF_WBYPASS_EN enables same-cycle write bypass.
package ex_regfile_mp_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RFIDX_W = 5;

`ifdef E203_CFG_REGNUM_IS_16
    localparam int DEF_RFREG_NUM = 16;
`else
    localparam int DEF_RFREG_NUM = 32;
`endif

`ifdef E203_RF_WBYPASS_EN
    localparam bit RF_WBYPASS = 1'b1;
`else
    localparam bit RF_WBYPASS = 1'b0;
`endif

    // The highest-numbered write-back port carries long-pipe (LSU/MULDIV) results.
    function automatic int lp_port(input int nwport);
        return nwport - 1;
    endfunction

endpackage

// File: rtl/ex_regfile_pend.sv
// Long-pipe pending scoreboard: one pend bit per register, WAW-guarding reservation
// handshake, incremental pending count. Bypass of clears follows E203_RF_WBYPASS_EN.
module ex_regfile_pend
    import ex_regfile_mp_pkg::*;
#(
    parameter int RFIDX_W   = DEF_RFIDX_W,
    parameter int RFREG_NUM = DEF_RFREG_NUM,
    parameter int NRPORT    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRPORT*RFIDX_W-1:0]   i_rd_idx,
    input  logic                        i_lp_set_vld,
    input  logic [RFIDX_W-1:0]          i_lp_set_idx,
    input  logic                        i_clr_vld,
    input  logic [RFIDX_W-1:0]          i_clr_idx,
    output logic [NRPORT-1:0]           o_rd_busy,
    output logic                        o_x1_busy,
    output logic                        o_lp_set_rdy,
    output logic [RFIDX_W:0]            o_lp_pend_cnt
);

    localparam int CW = RFIDX_W + 1;

    logic [RFREG_NUM-1:1] r_pend;
    logic [CW-1:0]        r_cnt;
    logic                 w_set_pend;
    logic                 w_clr_pend;
    logic                 w_set_ok;
    logic                 w_set_eff;
    logic                 w_clr_eff;

    function automatic logic pend_at(input logic [RFREG_NUM-1:1] v,
                                     input logic [RFIDX_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 1; i < RFREG_NUM; i++)
            if (idx == RFIDX_W'(i)) b = v[i];
        return b;
    endfunction

    function automatic logic busy_at(input logic [RFIDX_W-1:0] idx);
        logic b;
        b = pend_at(r_pend, idx);
`ifdef E203_RF_WBYPASS_EN
        if (i_clr_vld && (i_clr_idx == idx) && !(w_set_eff && (i_lp_set_idx == idx)))
            b = 1'b0;
`endif
        return b;
    endfunction

    assign w_set_pend   = pend_at(r_pend, i_lp_set_idx);
    assign w_clr_pend   = pend_at(r_pend, i_clr_idx);
    // A pending target may be re-reserved only in the cycle its write-back lands.
    assign o_lp_set_rdy = ~(w_set_pend & ~(i_clr_vld & (i_clr_idx == i_lp_set_idx)));
    assign w_set_ok     = (i_lp_set_idx != '0) && (int'(i_lp_set_idx) < RFREG_NUM);
    assign w_set_eff    = i_lp_set_vld & o_lp_set_rdy & w_set_ok;
    assign w_clr_eff    = i_clr_vld & w_clr_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 1; i < RFREG_NUM; i++) begin
                if (w_set_eff && (i_lp_set_idx == RFIDX_W'(i)))
                    r_pend[i] <= 1'b1;
                else if (i_clr_vld && (i_clr_idx == RFIDX_W'(i)))
                    r_pend[i] <= 1'b0;
            end
            r_cnt <= r_cnt + CW'(w_set_eff) - CW'(w_clr_eff);
        end
    end

    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < NRPORT; p++)
            o_rd_busy[p] = busy_at(i_rd_idx[p*RFIDX_W +: RFIDX_W]);
    end

    assign o_x1_busy     = busy_at(RFIDX_W'(1));
    assign o_lp_pend_cnt = r_cnt;

endmodule

// File: rtl/ex_regfile_mp.sv
// Multi-port integer register file with long-pipe pending scoreboard and x1 export.
// Defining E203_RF_WBYPASS_EN forwards same-cycle write data to the read ports.
module ex_regfile_mp
    import ex_regfile_mp_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int RFIDX_W   = DEF_RFIDX_W,
    parameter int RFREG_NUM = DEF_RFREG_NUM,
    parameter int NRPORT    = 2,
    parameter int NWPORT    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRPORT*RFIDX_W-1:0]   rd_idx,
    output logic [NRPORT*XLEN-1:0]      rd_dat,
    output logic [NRPORT-1:0]           rd_busy,
    input  logic [NWPORT-1:0]           wb_wen,
    input  logic [NWPORT*RFIDX_W-1:0]   wb_idx,
    input  logic [NWPORT*XLEN-1:0]      wb_dat,
    input  logic                        lp_set_vld,
    input  logic [RFIDX_W-1:0]          lp_set_idx,
    output logic                        lp_set_rdy,
    output logic [RFIDX_W:0]            lp_pend_cnt,
    output logic [XLEN-1:0]             x1_r,
    output logic                        x1_busy
);

    localparam int LP = lp_port(NWPORT);

    logic [NWPORT-1:0]    w_wen;
    logic [RFREG_NUM-1:1] w_we;
    logic [XLEN-1:0]      w_wd [1:RFREG_NUM-1];
    logic [XLEN-1:0]      w_rf [1:RFREG_NUM-1];

    // Writes are squashed while in reset so bypassed data cannot leak to the outputs.
    assign w_wen = wb_wen & {NWPORT{rst_n}};

    // Per-register arbitration: scanning ports downward leaves the lowest port as winner.
    always_comb begin
        for (int i = 1; i < RFREG_NUM; i++) begin
            w_we[i] = 1'b0;
            w_wd[i] = '0;
            for (int k = NWPORT - 1; k >= 0; k--) begin
                if (w_wen[k] && (wb_idx[k*RFIDX_W +: RFIDX_W] == RFIDX_W'(i))) begin
                    w_we[i] = 1'b1;
                    w_wd[i] = wb_dat[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar g = 1; g < RFREG_NUM; g++) begin : g_reg
        logic [XLEN-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (w_we[g])
                r_q <= w_wd[g];
        end
        assign w_rf[g] = r_q;
    end

    always_comb begin
        rd_dat = '0;
        for (int p = 0; p < NRPORT; p++) begin
            for (int i = 1; i < RFREG_NUM; i++) begin
                if (rd_idx[p*RFIDX_W +: RFIDX_W] == RFIDX_W'(i)) begin
`ifdef E203_RF_WBYPASS_EN
                    rd_dat[p*XLEN +: XLEN] = w_we[i] ? w_wd[i] : w_rf[i];
`else
                    rd_dat[p*XLEN +: XLEN] = w_rf[i];
`endif
                end
            end
        end
    end

`ifdef E203_RF_WBYPASS_EN
    assign x1_r = w_we[1] ? w_wd[1] : w_rf[1];
`else
    assign x1_r = w_rf[1];
`endif

    ex_regfile_pend #(
        .RFIDX_W   (RFIDX_W),
        .RFREG_NUM (RFREG_NUM),
        .NRPORT    (NRPORT)
    ) u_pend (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_idx      (rd_idx),
        .i_lp_set_vld  (lp_set_vld),
        .i_lp_set_idx  (lp_set_idx),
        .i_clr_vld     (w_wen[LP]),
        .i_clr_idx     (wb_idx[LP*RFIDX_W +: RFIDX_W]),
        .o_rd_busy     (rd_busy),
        .o_x1_busy     (x1_busy),
        .o_lp_set_rdy  (lp_set_rdy),
        .o_lp_pend_cnt (lp_pend_cnt)
    );

endmodule

// File: tb/tb_ex_regfile_mp.sv
// Directed bench for ex_regfile_mp: reset, dual/conflicting writes, reservation
// handshake, x1 export (bypass-aware) and asynchronous reset mid-operation.
module tb_ex_regfile_mp;

    localparam int XLEN = 32, RFIDX_W = 5, NRPORT = 2, NWPORT = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NRPORT*RFIDX_W-1:0] rd_idx;
    logic [NRPORT*XLEN-1:0]    rd_dat;
    logic [NRPORT-1:0]         rd_busy;
    logic [NWPORT-1:0]         wb_wen;
    logic [NWPORT*RFIDX_W-1:0] wb_idx;
    logic [NWPORT*XLEN-1:0]    wb_dat;
    logic                      lp_set_vld;
    logic [RFIDX_W-1:0]        lp_set_idx;
    logic                      lp_set_rdy;
    logic [RFIDX_W:0]          lp_pend_cnt;
    logic [XLEN-1:0]           x1_r;
    logic                      x1_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (rd_idx),
        .rd_dat      (rd_dat),
        .rd_busy     (rd_busy),
        .wb_wen      (wb_wen),
        .wb_idx      (wb_idx),
        .wb_dat      (wb_dat),
        .lp_set_vld  (lp_set_vld),
        .lp_set_idx  (lp_set_idx),
        .lp_set_rdy  (lp_set_rdy),
        .lp_pend_cnt (lp_pend_cnt),
        .x1_r        (x1_r),
        .x1_busy     (x1_busy)
    );

    task automatic drive_idle();
        wb_wen     = '0;
        wb_idx     = '0;
        wb_dat     = '0;
        lp_set_vld = 1'b0;
        lp_set_idx = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        rd_idx = '0;
        drive_idle();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (lp_set_rdy !== 1'b1 || lp_pend_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_hold rdy=%b cnt=%0d exp rdy=1 cnt=0", lp_set_rdy, lp_pend_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            next_cycle();
            rd_idx = {5'(31 - i), 5'(i)};
            @(negedge clk);
            n_vec++;
            if (rd_dat !== 64'h0 || rd_busy !== 2'b00) begin
                n_err++;
                $display("FAIL reset_read i=%0d dat=%h busy=%b exp 0/0", i, rd_dat, rd_busy);
            end
        end
        n_vec++;
        if (x1_r !== 32'h0 || x1_busy !== 1'b0 || lp_pend_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_x1 x1=%h busy=%b cnt=%0d exp 0/0/0", x1_r, x1_busy, lp_pend_cnt);
        end
    endtask

    task automatic test_dual_write();
        next_cycle();
        wb_wen = 2'b11;
        wb_idx = {5'd6, 5'd5};
        wb_dat = {32'hDEAD_BEEF, 32'h1234_5678};
        rd_idx = {5'd6, 5'd5};
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (rd_dat !== {32'hDEAD_BEEF, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL dual_write got %h exp deadbeef12345678", rd_dat);
        end
        next_cycle();
        wb_wen = 2'b01;
        wb_idx = {5'd0, 5'd0};
        wb_dat = {32'h0, 32'hFFFF_FFFF};
        rd_idx = {5'd5, 5'd0};
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (rd_dat !== {32'h1234_5678, 32'h0}) begin
            n_err++;
            $display("FAIL x0_write got %h exp 1234567800000000", rd_dat);
        end
    endtask

    task automatic test_same_index();
        next_cycle();
        wb_wen = 2'b11;
        wb_idx = {5'd7, 5'd7};
        wb_dat = {32'h5555_5555, 32'hAAAA_AAAA};
        rd_idx = {5'd7, 5'd7};
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (rd_dat !== {32'hAAAA_AAAA, 32'hAAAA_AAAA}) begin
            n_err++;
            $display("FAIL same_index got %h exp aaaaaaaaaaaaaaaa", rd_dat);
        end
    endtask

    task automatic test_reservation();
        next_cycle();
        lp_set_vld = 1'b1;
        lp_set_idx = 5'd10;
        rd_idx     = {5'd0, 5'd10};
        @(negedge clk);
        n_vec++;
        if (lp_set_rdy !== 1'b1 || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL resv_first rdy=%b busy=%b exp 1/00", lp_set_rdy, rd_busy);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (rd_busy !== 2'b01 || lp_pend_cnt !== 6'd1 || lp_set_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL resv_waw busy=%b cnt=%0d rdy=%b exp 01/1/0", rd_busy, lp_pend_cnt, lp_set_rdy);
        end
        next_cycle();
        wb_wen = 2'b10;
        wb_idx = {5'd10, 5'd0};
        wb_dat = {32'h42, 32'h0};
        @(negedge clk);
        n_vec++;
        if (lp_set_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL resv_clr_rdy rdy=%b exp 1", lp_set_rdy);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (rd_busy !== 2'b01 || lp_pend_cnt !== 6'd1 || rd_dat[31:0] !== 32'h42) begin
            n_err++;
            $display("FAIL resv_set_wins busy=%b cnt=%0d dat=%h exp 01/1/42", rd_busy, lp_pend_cnt, rd_dat[31:0]);
        end
    endtask

    task automatic test_x1();
        logic [31:0] exp_x1;
        logic        exp_busy;
        next_cycle();
        lp_set_vld = 1'b1;
        lp_set_idx = 5'd1;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (x1_busy !== 1'b1 || lp_pend_cnt !== 6'd2) begin
            n_err++;
            $display("FAIL x1_set busy=%b cnt=%0d exp 1/2", x1_busy, lp_pend_cnt);
        end
        next_cycle();
        wb_wen = 2'b10;
        wb_idx = {5'd1, 5'd0};
        wb_dat = {32'h8000_0100, 32'h0};
`ifdef E203_RF_WBYPASS_EN
        exp_x1   = 32'h8000_0100;
        exp_busy = 1'b0;
`else
        exp_x1   = 32'h0;
        exp_busy = 1'b1;
`endif
        @(negedge clk);
        n_vec++;
        if (x1_r !== exp_x1 || x1_busy !== exp_busy) begin
            n_err++;
            $display("FAIL x1_same_cycle x1=%h busy=%b exp %h/%b", x1_r, x1_busy, exp_x1, exp_busy);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (x1_r !== 32'h8000_0100 || x1_busy !== 1'b0 || lp_pend_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL x1_after x1=%h busy=%b cnt=%0d exp 80000100/0/1", x1_r, x1_busy, lp_pend_cnt);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        lp_set_vld = 1'b1;
        lp_set_idx = 5'd2;
        next_cycle();
        lp_set_idx = 5'd3;
        next_cycle();
        drive_idle();
        rd_idx = {5'd3, 5'd2};
        @(negedge clk);
        n_vec++;
        if (lp_pend_cnt !== 6'd3 || rd_busy !== 2'b11) begin
            n_err++;
            $display("FAIL mid_pending cnt=%0d busy=%b exp 3/11", lp_pend_cnt, rd_busy);
        end
        next_cycle();
        wb_wen     = 2'b01;
        wb_idx     = {5'd0, 5'd12};
        wb_dat     = {32'h0, 32'h77};
        lp_set_vld = 1'b1;
        lp_set_idx = 5'd4;
        rd_idx     = {5'd10, 5'd12};
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (rd_dat !== 64'h0 || rd_busy !== 2'b00 || x1_r !== 32'h0 || x1_busy !== 1'b0 ||
            lp_pend_cnt !== 6'd0 || lp_set_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset dat=%h busy=%b x1=%h x1b=%b cnt=%0d rdy=%b exp all 0, rdy 1",
                     rd_dat, rd_busy, x1_r, x1_busy, lp_pend_cnt, lp_set_rdy);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        rd_idx = {5'd5, 5'd12};
        @(negedge clk);
        n_vec++;
        if (rd_dat !== 64'h0 || lp_pend_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL mid_after dat=%h cnt=%0d busy=%b exp 0/0/00", rd_dat, lp_pend_cnt, rd_busy);
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_same_index();
        test_reservation();
        test_x1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_regfile_mp.md
# ex_regfile_mp

Parametrised multi-port integer register file with a per-register long-pipe pending scoreboard. It replaces the single-write, dual-read register file in the EXU. It serves NRPORT read ports and NWPORT write-back ports, and tracks registers whose write-back is owed by the long pipe (LSU/MULDIV). It exports x1 together with its pending state, so IFU early JALR resolution can tell when x1 is stale.

## Interface
Parameters:
- XLEN, 32, data width
- RFIDX_W, 5, register index width
- RFREG_NUM, 32, number of architectural registers (16 for RV32E); indices ≥ RFREG_NUM read as 0 and are never written
- NRPORT, 2, read ports
- NWPORT, 2, write-back ports; port NWPORT-1 is the long-pipe port

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_idx  in  NRPORT*RFIDX_W  read indices, port p at slice p
- rd_dat  out  NRPORT*XLEN  read data
- rd_busy  out  NRPORT  indexed register is pending
- wb_wen  in  NWPORT  write enables
- wb_idx  in  NWPORT*RFIDX_W  write indices
- wb_dat  in  NWPORT*XLEN  write data
- lp_set_vld  in  1  long-pipe dispatch: mark lp_set_idx pending
- lp_set_idx  in  RFIDX_W  destination being reserved
- lp_set_rdy  out  1  reservation accepted
- lp_pend_cnt  out  RFIDX_W+1  number of pending registers
- x1_r  out  XLEN  x1 contents
- x1_busy  out  1  x1 pending

## Operation
- **x0.** Reads as 0. Writes to x0 are dropped. lp_set on x0 is accepted but sets no bit and does not count.
- **Data storage.** Registers 1..RFREG_NUM-1 use enable-flops. Reset value is 0.
- **Write.** When wb_wen[k]=1 and wb_idx[k] is nonzero and in range, the register takes wb_dat[k] at the next edge.
- **Same-index write conflict.** If several ports write the same index in one cycle, the lowest port index wins.
- **Scoreboard.** Each register 1..RFREG_NUM-1 has one pend bit.
  - **Set:** on lp_set_vld & lp_set_rdy.
  - **Clear:** on wb_wen[NWPORT-1] to that index.
- **lp_set_rdy.**
  - 0 when the target's pend bit is already set and is not being cleared this cycle, to avoid WAW on the long pipe.
  - Otherwise 1.
  - Depends combinationally only on scoreboard state, lp_set_idx and the port NWPORT-1 write.
  - The producer holds lp_set_vld/lp_set_idx stable until rdy.
- **Set and clear of the same index in one cycle.** Set wins; the bit stays 1.
- **Writes from ports other than NWPORT-1.** They never touch pend bits.
- **lp_pend_cnt.** A registered popcount, kept incrementally: +1 on accepted set, -1 on clear. When set and clear hit the same cycle:
  - different indices: count unchanged;
  - same index: count unchanged.
- **Reset.** Asynchronous. It clears all data, all pend bits and the count. Reset asserted mid-operation discards in-flight writes and reservations.

## Timing
- Reads are combinational from state (plus the bypass below when configured).
- Write-to-read latency is 1 cycle: the read the cycle after the write edge returns the new value.
- A pend bit becomes visible on rd_busy and x1_busy the cycle after the set.
- Outputs during and after reset: rd_dat=0, rd_busy=0, x1_r=0, x1_busy=0, lp_pend_cnt=0, lp_set_rdy=1.

## Configuration
- **E203_RF_WBYPASS_EN defined:**
  - A read whose index matches a same-cycle write returns that write's data, using the winning port under the lowest-index rule.
  - rd_busy and x1_busy read 0 for an index being cleared that cycle, unless it is also being set.
  - This applies to x1_r/x1_busy too.
- **E203_RF_WBYPASS_EN undefined:**
  - Reads reflect flop state only.
  - The new value and cleared busy appear one cycle later.

## Structure
- **Shared package/define file:**
  - default XLEN, RFIDX_W and RFREG_NUM (keyed to the RV32E define);
  - the long-pipe port index constant (NWPORT-1);
  - the bypass macro.
- **Sub-module ex_regfile_pend:**
  - pend bit vector, lp_set_rdy, lp_pend_cnt;
  - pend lookups for the read ports.
- **Top level:** data flops, write-port arbitration, read muxes, bypass.

## Test plan
- **Reset, then read.** Reset, then read all indices on every port -> rd_dat=0, rd_busy=0, lp_pend_cnt=0.
- **Dual write, no conflict.**
  - Port0 writes x5=0x1234_5678 and port1 writes x6=0xDEAD_BEEF in the same cycle.
  - Next cycle: both values read back.
  - A write to x0 -> x0 still reads 0.
- **Dual write, same index.** Both ports write x7 (0xAAAA_AAAA on port0, 0x5555_5555 on port1) -> x7=0xAAAA_AAAA.
- **Reservation and WAW stall.**
  - lp_set x10 -> next cycle rd_busy=1 for x10 and lp_pend_cnt=1.
  - A second lp_set x10 -> lp_set_rdy=0.
  - Port1 write x10=0x42 -> that cycle lp_set_rdy=1, and the set wins: busy stays 1 and cnt stays 1.
- **x1 export.**
  - lp_set x1 -> x1_busy=1.
  - Port1 write x1=0x8000_0100: with bypass, x1_r=0x8000_0100 and x1_busy=0 in the same cycle; without bypass, both appear one cycle later.
- **Reset mid-operation.** Assert rst_n low with 3 pending registers and a write in flight -> all outputs 0 immediately and lp_set_rdy=1; the write is not committed after release.
